orient_rot_engine: RTL and testbench

- Multi-lane, multi-cycle successor to the combinational cube ALU.
- Accepts one command covering LANES orientation words per transaction. Each command is either a rotation (axis plus 0–3 quarter turns) or one of INC/DEC/CHECK/MOV.
- Rotations execute iteratively, one quarter turn per cycle.
- Sits between the cube-state register file and the move sequencer. Uses valid/ready handshakes on both sides.

---
 rtl/orient_rot_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_orient_rot_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/orient_rot_engine.sv
`default_nettype none
// ============================================================================
// Module   : orient_rot_engine
// Brief    : Multi-lane orientation engine. It rotates the 3-bit orientation
//            code in each lane one quarter turn per cycle, or performs
//            INC/DEC/CHECK/MOV on the full lane words.
//            With macro ROT_FAST_EN defined, rotation finishes in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module orient_rot_engine #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [1:0]               in_axis,
    input  logic [1:0]               in_turns,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic [WIDTH-1:0]         in_cmp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic [LANES-1:0]         out_zf,
    output logic                     out_err
);

    localparam logic [2:0] c_OP_ROT = 3'd0;
    localparam logic [2:0] c_OP_INC = 3'd1;
    localparam logic [2:0] c_OP_DEC = 3'd2;
    localparam logic [2:0] c_OP_CHK = 3'd3;
    localparam logic [2:0] c_OP_MOV = 3'd4;

    localparam logic [1:0] c_AX_RL  = 2'd0;
    localparam logic [1:0] c_AX_UD  = 2'd1;
    localparam logic [1:0] c_AX_FB  = 2'd2;
    localparam logic [1:0] c_AX_BAD = 2'd3;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
`ifndef ROT_FAST_EN
    localparam logic [1:0] c_ST_ROT  = 2'd1;
`endif
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    // One quarter turn; codes not on the axis cycle (and illegal codes) hold.
    function automatic logic [2:0] f_step(input logic [2:0] code, input logic [1:0] axis);
        f_step = code;
        case (axis)
            c_AX_RL: case (code)
                3'd0: f_step = 3'd2;
                3'd2: f_step = 3'd5;
                3'd5: f_step = 3'd4;
                3'd4: f_step = 3'd0;
                default: f_step = code;
            endcase
            c_AX_UD: case (code)
                3'd0: f_step = 3'd1;
                3'd1: f_step = 3'd5;
                3'd5: f_step = 3'd3;
                3'd3: f_step = 3'd0;
                default: f_step = code;
            endcase
            c_AX_FB: case (code)
                3'd1: f_step = 3'd4;
                3'd2: f_step = 3'd1;
                3'd3: f_step = 3'd2;
                3'd4: f_step = 3'd3;
                default: f_step = code;
            endcase
            default: f_step = code;
        endcase
    endfunction

`ifdef ROT_FAST_EN
    // Unrolled composition, which resolves to a flat 90/180/270 lookup.
    function automatic logic [2:0] f_rot_n(input logic [2:0] code, input logic [1:0] axis,
                                           input logic [1:0] turns);
        logic [2:0] c;
        c = code;
        for (int k = 0; k < 3; k++) begin
            if (k < int'(turns)) c = f_step(c, axis);
        end
        f_rot_n = c;
    endfunction
`endif

    logic [1:0]             r_state, w_state_nxt;
    logic [LANES*WIDTH-1:0] r_data,  w_data_nxt;
    logic [LANES-1:0]       r_zf,    w_zf_nxt;
    logic                   r_err,   w_err_nxt;

    logic [LANES*WIDTH-1:0] w_in_rot;
    logic [LANES*WIDTH-1:0] w_in_inc;
    logic [LANES*WIDTH-1:0] w_in_dec;
    logic [LANES-1:0]       w_in_eq;
    logic [LANES-1:0]       w_in_ill;

`ifndef ROT_FAST_EN
    logic [1:0]             r_cnt,  w_cnt_nxt;
    logic [1:0]             r_axis, w_axis_nxt;
    logic [LANES*WIDTH-1:0] w_step;
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WIDTH-1:0] w_word;
        logic [WIDTH-1:0] w_rot_word;

        assign w_word = in_data[gi*WIDTH +: WIDTH];
        assign w_in_ill[gi] = &w_word[2:1];
        assign w_in_inc[gi*WIDTH +: WIDTH] = w_word + c_ONE;
        assign w_in_dec[gi*WIDTH +: WIDTH] = w_word - c_ONE;
        assign w_in_eq[gi] = (w_word == in_cmp);

        // Payload bits above the code pass through untouched.
        always_comb begin
            w_rot_word = w_word;
`ifdef ROT_FAST_EN
            w_rot_word[2:0] = f_rot_n(w_word[2:0], in_axis, in_turns);
`else
            w_rot_word[2:0] = f_step(w_word[2:0], in_axis);
`endif
        end
        assign w_in_rot[gi*WIDTH +: WIDTH] = w_rot_word;

`ifndef ROT_FAST_EN
        logic [WIDTH-1:0] w_cur;
        logic [WIDTH-1:0] w_cur_step;
        assign w_cur = r_data[gi*WIDTH +: WIDTH];
        always_comb begin
            w_cur_step      = w_cur;
            w_cur_step[2:0] = f_step(w_cur[2:0], r_axis);
        end
        assign w_step[gi*WIDTH +: WIDTH] = w_cur_step;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_zf_nxt    = r_zf;
        w_err_nxt   = r_err;
`ifndef ROT_FAST_EN
        w_cnt_nxt   = r_cnt;
        w_axis_nxt  = r_axis;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = c_ST_DONE;
                    w_data_nxt  = in_data;
                    w_zf_nxt    = '0;
                    w_err_nxt   = 1'b0;
`ifndef ROT_FAST_EN
                    w_axis_nxt  = in_axis;
`endif
                    case (in_op)
                        c_OP_ROT: begin
                            if (in_axis == c_AX_BAD) begin
                                w_err_nxt = 1'b1;
                            end else begin
                                w_err_nxt = |w_in_ill;
                                // The first quarter turn lands on the accept edge.
                                if (in_turns != 2'd0) begin
                                    w_data_nxt = w_in_rot;
`ifndef ROT_FAST_EN
                                    if (in_turns != 2'd1) begin
                                        w_state_nxt = c_ST_ROT;
                                        w_cnt_nxt   = in_turns - 2'd1;
                                    end
`endif
                                end
                            end
                        end
                        c_OP_INC: w_data_nxt = w_in_inc;
                        c_OP_DEC: w_data_nxt = w_in_dec;
                        c_OP_CHK: w_zf_nxt   = w_in_eq;
                        c_OP_MOV: w_data_nxt = in_data;
                        default:  w_err_nxt  = 1'b1;
                    endcase
                end
            end
`ifndef ROT_FAST_EN
            c_ST_ROT: begin
                w_data_nxt = w_step;
                w_cnt_nxt  = r_cnt - 2'd1;
                if (r_cnt == 2'd1) w_state_nxt = c_ST_DONE;
            end
`endif
            c_ST_DONE: begin
                if (out_ready) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_data  <= '0;
            r_zf    <= '0;
            r_err   <= 1'b0;
`ifndef ROT_FAST_EN
            r_cnt   <= 2'd0;
            r_axis  <= 2'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_zf    <= w_zf_nxt;
            r_err   <= w_err_nxt;
`ifndef ROT_FAST_EN
            r_cnt   <= w_cnt_nxt;
            r_axis  <= w_axis_nxt;
`endif
        end
    end

    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_DONE);
    assign out_data  = r_data;
    assign out_zf    = r_zf;
    assign out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_orient_rot_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_orient_rot_engine
// Brief    : Scoreboard bench for orient_rot_engine using a vector-rotation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_orient_rot_engine;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int DW    = WIDTH * LANES;
`ifdef ROT_FAST_EN
    localparam bit c_FAST = 1'b1;
`else
    localparam bit c_FAST = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [1:0]       in_axis = '0;
    logic [1:0]       in_turns = '0;
    logic [DW-1:0]    in_data = '0;
    logic [WIDTH-1:0] in_cmp = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [DW-1:0]    out_data;
    logic [LANES-1:0] out_zf;
    logic             out_err;

    always #5 clk = ~clk;

    orient_rot_engine #(.WIDTH(WIDTH), .LANES(LANES)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_axis(in_axis), .in_turns(in_turns),
        .in_data(in_data), .in_cmp(in_cmp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zf(out_zf), .out_err(out_err)
    );

    typedef struct {
        logic [DW-1:0]    data;
        logic [LANES-1:0] zf;
        logic             err;
        int               lat;
    } exp_t;

    exp_t          sb_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] last_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Orientation as a unit vector, rotated as a right-handed quarter turn.
    function automatic logic [2:0] m_rot(input logic [2:0] c, input logic [1:0] ax, input int n);
        int x, y, z, t;
        if (c > 3'd5) return c;
        x = 0; y = 0; z = 0;
        case (c)
            3'd0: y = 1;
            3'd1: x = 1;
            3'd2: z = 1;
            3'd3: x = -1;
            3'd4: z = -1;
            default: y = -1;
        endcase
        for (int k = 0; k < n; k++) begin
            case (ax)
                2'd0: begin t = y; y = -z; z = t; end
                2'd1: begin t = x; x = y;  y = -t; end
                default: begin t = x; x = z; z = -t; end
            endcase
        end
        if (y == 1) return 3'd0;
        if (x == 1) return 3'd1;
        if (z == 1) return 3'd2;
        if (x == -1) return 3'd3;
        if (z == -1) return 3'd4;
        return 3'd5;
    endfunction

    function automatic exp_t m_expect(input logic [2:0] op, input logic [1:0] ax, input logic [1:0] tn,
                                      input logic [DW-1:0] d, input logic [WIDTH-1:0] cmp);
        exp_t e;
        logic [WIDTH-1:0] w;
        e.data = d; e.zf = '0; e.err = 1'b0; e.lat = 1;
        if (op > 3'd4 || (op == 3'd0 && ax == 2'd3)) begin
            e.err = 1'b1;
            return e;
        end
        for (int i = 0; i < LANES; i++) begin
            w = d[i*WIDTH +: WIDTH];
            case (op)
                3'd0: begin
                    if (w[2:0] > 3'd5) e.err = 1'b1;
                    w[2:0] = m_rot(w[2:0], ax, int'(tn));
                end
                3'd1: w = w + 8'd1;
                3'd2: w = w - 8'd1;
                3'd3: e.zf[i] = (w == cmp);
                default: ;
            endcase
            e.data[i*WIDTH +: WIDTH] = w;
        end
        if (op == 3'd0 && !c_FAST && tn > 2'd1) e.lat = int'(tn);
        return e;
    endfunction

    // Issue one command, then check its result against the head of the scoreboard.
    task automatic do_cmd(input logic [2:0] op, input logic [1:0] ax, input logic [1:0] tn,
                          input logic [DW-1:0] d, input logic [WIDTH-1:0] cmp, input int hold);
        exp_t e;
        int   lat;
        int   guard;
        logic [DW-1:0] held;
        sb_q.push_back(m_expect(op, ax, tn, d, cmp));
        @(negedge clk);
        if (hold > 0) out_ready = 1'b0;
        in_valid = 1'b1; in_op = op; in_axis = ax; in_turns = tn; in_data = d; in_cmp = cmp;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("accept_timeout", 1, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        e = sb_q.pop_front();
        chk("out_valid", out_valid, 1);
        chk("latency", lat, e.lat);
        chk("out_data", out_data, e.data);
        chk("out_zf", out_zf, e.zf);
        chk("out_err", out_err, e.err);
        last_data = out_data;
        if (hold > 0) begin
            held = out_data;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held);
                chk("hold_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("drop_valid", out_valid, 0);
        chk("ready_again", in_ready, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_zf", out_zf, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_in_ready", in_ready, 1);

        do_cmd(3'd0, 2'd0, 2'd1, 32'h03_25_12_08, 8'h00, 0);
        chk("rl_example", last_data, 32'h03_24_15_0A);
        do_cmd(3'd0, 2'd1, 2'd3, 32'h00_00_00_00, 8'h00, 0);
        chk("ud_example", last_data, 32'h03_03_03_03);
        do_cmd(3'd1, 2'd0, 2'd0, 32'h10_7F_00_FF, 8'h00, 0);
        chk("inc_example", last_data, 32'h11_80_01_00);
        do_cmd(3'd2, 2'd0, 2'd0, 32'h00_00_00_00, 8'h00, 0);
        chk("dec_example", last_data, 32'hFF_FF_FF_FF);
        do_cmd(3'd3, 2'd0, 2'd0, 32'h00_2A_2B_2A, 8'h2A, 0);
        do_cmd(3'd0, 2'd2, 2'd2, 32'h00_00_01_06, 8'h00, 0);
        chk("fb_example", last_data, 32'h00_00_03_06);
        do_cmd(3'd0, 2'd3, 2'd2, 32'h12_34_56_78, 8'h00, 0);
        do_cmd(3'd0, 2'd1, 2'd0, 32'h2D_0A_13_44, 8'h00, 0);
        do_cmd(3'd4, 2'd0, 2'd0, 32'hDE_AD_BE_EF, 8'h00, 0);
        do_cmd(3'd6, 2'd1, 2'd1, 32'hCA_FE_F0_0D, 8'h00, 0);
        do_cmd(3'd0, 2'd0, 2'd3, 32'h04_05_02_00, 8'h00, 5);

        for (int n = 0; n < 40; n++) begin
            do_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   DW'($urandom()), 8'($urandom()), 0);
        end

        // Abort a three-turn rotation with reset.
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd0; in_axis = 2'd1; in_turns = 2'd3; in_data = 32'h01_02_03_04;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_data", out_data, 0);
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", out_valid, 0);

        do_cmd(3'd0, 2'd2, 2'd1, 32'h04_03_02_01, 8'h00, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
